// File: rtl/vlsu_store_queue.sv
// vlsu_store_queue: parametrised store-data queue between the VRF and memory.
// A store command (vid, vl, vsew) is converted to a beat count; VRF beats are
// queued with {data, vid, last, strb} and drained first-word-fall-through over
// a valid/ready channel. s_done pulses one cycle after each store's last beat
// is accepted by memory (or one cycle after a vl=0 command).
// Optional feature macro: STQ_BYTE_STROBE_EN (store per-beat byte strobes so
// the final beat of a store carries a partial strobe).
module vlsu_store_queue #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 16,
   parameter int VL_W   = 32,
   parameter int TAG_W  = 3
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [TAG_W-1:0]           cmd_vid,
   input  logic [VL_W-1:0]            cmd_vl,
   input  logic [2:0]                 cmd_vsew,
   output logic                       cmd_err,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       mem_valid,
   input  logic                       mem_ready,
   output logic [DATA_W-1:0]          mem_data,
   output logic                       mem_last,
   output logic [TAG_W-1:0]           mem_vid,
   output logic [DATA_W/8-1:0]        mem_strb,
   output logic                       s_done,
   output logic [TAG_W-1:0]           s_done_vid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       busy
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int BW    = VL_W + 4;   // holds vl << 3 plus rounding headroom

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state_q, state_d;
   logic [TAG_W-1:0]  vid_q, vid_d;
   logic [BW-1:0]     rem_q, rem_d;
   logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic [TAG_W-1:0]  done_vid_q, done_vid_d;
   logic              hold_q, hold_d;
   logic [TAG_W-1:0]  hold_vid_q, hold_vid_d;

   logic [DATA_W-1:0] data_ram [DEPTH];
   logic [TAG_W-1:0]  vid_ram  [DEPTH];
   logic              last_ram [DEPTH];

   logic              cmd_fire, legal, zero_new, push, pop, push_last, pop_last;
   logic [BW-1:0]     bytes, beats;

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign legal     = (cmd_vsew < 3'd4);
   assign bytes     = BW'(cmd_vl) << cmd_vsew[1:0];
   assign beats     = (bytes + BW'(BYTES - 1)) >> OFF_W;
   assign zero_new  = cmd_fire && legal && (cmd_vl == '0);
   assign push      = in_valid && in_ready;
   assign pop       = mem_valid && mem_ready;
   assign push_last = (rem_q == BW'(1));
   assign pop_last  = pop && last_ram[rptr_q];

   // A deferred vl=0 completion briefly blocks new commands so that at most one
   // completion is ever waiting behind a last-beat completion.
   assign cmd_ready = (state_q == IDLE) && !hold_q;
   assign in_ready  = (state_q == FILL) && (count_q != CW'(DEPTH));
   assign mem_valid = (count_q != '0);
   assign mem_data  = mem_valid ? data_ram[rptr_q] : '0;
   assign mem_last  = mem_valid && last_ram[rptr_q];
   assign mem_vid   = mem_valid ? vid_ram[rptr_q] : '0;
   assign cmd_err   = err_q;
   assign s_done    = done_q;
   assign s_done_vid = done_vid_q;
   assign count     = count_q;
   assign busy      = (state_q == FILL) || (count_q != '0);

`ifdef STQ_BYTE_STROBE_EN
   logic [OFF_W-1:0]  tail_q, tail_d;
   logic [BYTES-1:0]  strb_ram [DEPTH];
   logic [BYTES-1:0]  wr_strb;

   // Only the final beat of a store with a partial tail gets a short strobe.
   always_comb begin
      wr_strb = '1;
      if (push_last && (tail_q != '0)) wr_strb = (BYTES'(1) << tail_q) - BYTES'(1);
   end

   assign mem_strb = mem_valid ? strb_ram[rptr_q] : '0;

   // Strobe storage alongside the data entries.
   always_ff @(posedge clk) begin
      if (push) strb_ram[wptr_q] <= wr_strb;
   end
`else
   assign mem_strb = {BYTES{mem_valid}};
`endif

   // Fill FSM: latch command in IDLE, count beats down in FILL.
   always_comb begin
      state_d = state_q;
      vid_d   = vid_q;
      rem_d   = rem_q;
      err_d   = 1'b0;
`ifdef STQ_BYTE_STROBE_EN
      tail_d  = tail_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               if (!legal) begin
                  err_d = 1'b1;
               end else if (cmd_vl != '0) begin
                  vid_d   = cmd_vid;
                  rem_d   = beats;
`ifdef STQ_BYTE_STROBE_EN
                  tail_d  = bytes[OFF_W-1:0];
`endif
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            if (push) begin
               rem_d = rem_q - BW'(1);
               if (push_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Queue pointers and occupancy.
   always_comb begin
      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   // Completion arbitration: last-beat pops win, a colliding vl=0 completion is held.
   always_comb begin
      done_d     = 1'b0;
      done_vid_d = '0;
      hold_d     = hold_q;
      hold_vid_d = hold_vid_q;
      if (pop_last) begin
         done_d     = 1'b1;
         done_vid_d = vid_ram[rptr_q];
         if (zero_new) begin
            hold_d     = 1'b1;
            hold_vid_d = cmd_vid;
         end
      end else if (hold_q) begin
         done_d     = 1'b1;
         done_vid_d = hold_vid_q;
         hold_d     = 1'b0;
      end else if (zero_new) begin
         done_d     = 1'b1;
         done_vid_d = cmd_vid;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         vid_q      <= '0;
         rem_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         done_vid_q <= '0;
         hold_q     <= 1'b0;
         hold_vid_q <= '0;
`ifdef STQ_BYTE_STROBE_EN
         tail_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         vid_q      <= vid_d;
         rem_q      <= rem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         err_q      <= err_d;
         done_q     <= done_d;
         done_vid_q <= done_vid_d;
         hold_q     <= hold_d;
         hold_vid_q <= hold_vid_d;
`ifdef STQ_BYTE_STROBE_EN
         tail_q     <= tail_d;
`endif
      end
   end

   // Entry storage; contents are qualified by count so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         data_ram[wptr_q] <= in_data;
         vid_ram[wptr_q]  <= vid_q;
         last_ram[wptr_q] <= push_last;
      end
   end

endmodule

// File: tb/tb_vlsu_store_queue.sv
// Testbench for vlsu_store_queue: directed steps with randomized data and
// mem_ready, checked every cycle against a queue-based reference model.
module tb_vlsu_store_queue;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         cmd_valid = 1'b0, cmd_ready;
   logic [2:0]   cmd_vid = '0;
   logic [31:0]  cmd_vl = '0;
   logic [2:0]   cmd_vsew = '0;
   logic         cmd_err;
   logic         in_valid = 1'b0, in_ready;
   logic [127:0] in_data = '0;
   logic         mem_valid, mem_ready = 1'b0;
   logic [127:0] mem_data;
   logic         mem_last;
   logic [2:0]   mem_vid;
   logic [15:0]  mem_strb;
   logic         s_done;
   logic [2:0]   s_done_vid;
   logic [4:0]   count;
   logic         busy;

   vlsu_store_queue dut (
      .clk(clk), .nrst(nrst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vid(cmd_vid),
      .cmd_vl(cmd_vl), .cmd_vsew(cmd_vsew), .cmd_err(cmd_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
      .mem_last(mem_last), .mem_vid(mem_vid), .mem_strb(mem_strb),
      .s_done(s_done), .s_done_vid(s_done_vid), .count(count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] d;
      int           vid;
      bit           last;
      logic [15:0]  strb;
   } beat_t;

   // Reference model state
   beat_t q[$];
   int    done_q[$];
   bit    m_fill, m_hold, m_err;
   int    m_vid, m_left, m_tail;

   int    n_total = 0, n_pass = 0;
   bit    pattern_mode = 1'b0, rnd_ready = 1'b0;
   int    beat_ctr = 0, done_seen = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [127:0] next_data();
      if (pattern_mode) return {4{beat_ctr[31:0]}};
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      q.delete(); done_q.delete();
      m_fill = 0; m_hold = 0; m_err = 0; m_vid = 0; m_left = 0; m_tail = 0;
   endtask

   // Check outputs at the negedge, advance the model by the handshakes that
   // will occur at the coming posedge, then move to the next negedge.
   task automatic cycle();
      bit cf, inf, pf, pl;
      chk("count", count, q.size());
      chk("mem_valid", mem_valid, q.size() != 0);
      chk("in_ready", in_ready, m_fill && q.size() < 16);
      chk("cmd_ready", cmd_ready, !m_fill && !m_hold);
      chk("cmd_err", cmd_err, m_err);
      chk("busy", busy, m_fill || q.size() != 0);
      chk("s_done", s_done, done_q.size() != 0);
      if (q.size() != 0) begin
         chk("mem_data", mem_data, q[0].d);
         chk("mem_last", mem_last, q[0].last);
         chk("mem_vid", mem_vid, q[0].vid);
         chk("mem_strb", mem_strb, q[0].strb);
      end
      if (done_q.size() != 0) begin
         chk("s_done_vid", s_done_vid, done_q[0]);
         void'(done_q.pop_front());
      end
      if (s_done) done_seen++;
      cf  = cmd_valid && !m_fill && !m_hold;
      inf = in_valid && m_fill && q.size() < 16;
      pf  = mem_ready && q.size() != 0;
      pl  = pf && q[0].last;
      m_err = cf && cmd_vsew >= 4;
      if (pl) done_q.push_back(q[0].vid);
      if (m_hold && !pl) m_hold = 0;
      if (pf) void'(q.pop_front());
      if (inf) begin
         beat_t b;
         b.d = in_data; b.vid = m_vid; b.last = (m_left == 1); b.strb = 16'hFFFF;
`ifdef STQ_BYTE_STROBE_EN
         if (b.last && m_tail != 0) b.strb = (16'h1 << m_tail) - 16'h1;
`endif
         q.push_back(b);
         m_left--;
         if (b.last) m_fill = 0;
      end
      if (cf && cmd_vsew < 4) begin
         if (cmd_vl == 0) begin
            if (pl) m_hold = 1;
            done_q.push_back(int'(cmd_vid));
         end else begin
            longint bytes = longint'(cmd_vl) << cmd_vsew;
            m_vid = cmd_vid; m_left = int'((bytes + 15) / 16); m_tail = int'(bytes % 16);
            m_fill = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (inf) begin beat_ctr++; in_data = next_data(); end
      if (rnd_ready) mem_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_cmd(input int vid, input int vl, input int vsew);
      int n = 0;
      cmd_vid = 3'(vid); cmd_vl = 32'(vl); cmd_vsew = 3'(vsew); cmd_valid = 1;
      while (!(!m_fill && !m_hold) && n < 200) begin cycle(); n++; end
      if (n >= 200) chk("cmd_wait_timeout", 1, 0);
      cycle();
      cmd_valid = 0;
   endtask

   task automatic push_all();
      int n = 0;
      in_valid = 1;
      while (m_fill && n < 500) begin cycle(); n++; end
      if (n >= 500) chk("push_timeout", 1, 0);
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || m_fill || done_q.size() != 0) && n < 1000) begin cycle(); n++; end
      if (n >= 1000) chk("drain_timeout", 1, 0);
      cycle();
   endtask

   task automatic chk_reset_vals();
      chk("rst_cmd_ready", cmd_ready, 1); chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_valid", mem_valid, 0); chk("rst_mem_last", mem_last, 0);
      chk("rst_mem_data", mem_data, 0);   chk("rst_mem_vid", mem_vid, 0);
      chk("rst_mem_strb", mem_strb, 0);   chk("rst_s_done", s_done, 0);
      chk("rst_s_done_vid", s_done_vid, 0); chk("rst_cmd_err", cmd_err, 0);
      chk("rst_count", count, 0);         chk("rst_busy", busy, 0);
   endtask

   initial begin
      model_reset();
      // Reset values
      @(negedge clk); @(negedge clk);
      chk_reset_vals();
      nrst = 1;
      cycle();

      // 8-beat store, pattern data, memory always ready
      pattern_mode = 1; beat_ctr = 0; in_data = next_data(); mem_ready = 1;
      send_cmd(3, 32, 2);
      push_all();
      drain();

      // 20-beat store against a stalled memory: fills to DEPTH then wraps on drain
      beat_ctr = 0; in_data = next_data(); mem_ready = 0;
      send_cmd(1, 80, 2);
      in_valid = 1;
      repeat (20) cycle();
      chk("full_count", count, 16);
      chk("full_in_ready", in_ready, 0);
      mem_ready = 1;
      push_all();
      drain();

      // 10-byte store: single partial beat
      pattern_mode = 0; in_data = next_data(); mem_ready = 0;
      send_cmd(5, 5, 1);
      push_all();
      cycle();
      chk("tail_last", mem_last, 1);
`ifdef STQ_BYTE_STROBE_EN
      chk("tail_strb", mem_strb, 16'h03FF);
`else
      chk("tail_strb", mem_strb, 16'hFFFF);
`endif
      mem_ready = 1;
      drain();

      // Illegal vsew, then a vl=0 store
      in_valid = 1;
      send_cmd(2, 10, 5);
      chk("err_pulse", cmd_err, 1);
      chk("err_no_fill", in_ready, 0);
      cycle();
      in_valid = 0;
      send_cmd(6, 0, 0);
      chk("zero_done", s_done, 1);
      chk("zero_done_vid", s_done_vid, 6);
      chk("zero_count", count, 0);
      drain();

      // Back-to-back stores with random mem_ready
      rnd_ready = 1; done_seen = 0; in_data = next_data();
      send_cmd(1, 16, 2);
      push_all();
      send_cmd(2, 16, 2);
      push_all();
      drain();
      chk("b2b_done_count", done_seen, 2);

      // Random stores of varying sizes
      for (int i = 0; i < 12; i++) begin
         send_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 40)), int'($urandom_range(0, 3)));
         push_all();
      end
      drain();

      // Reset mid-store after 3 of 8 beats
      rnd_ready = 0; mem_ready = 0;
      send_cmd(4, 32, 2);
      in_valid = 1;
      while (q.size() < 3) cycle();
      in_valid = 0;
      nrst = 0;
      #1;
      chk_reset_vals();
      model_reset();
      @(negedge clk);
      nrst = 1;
      cycle();
      chk("post_rst_count", count, 0);
      mem_ready = 1;
      send_cmd(7, 12, 3);
      push_all();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
